modulation_segment_swap: RTL and testbench

Sits directly downstream of the modulation timer and consumes its per-segment sample indices and its settings-update strobe. It selects which of the two modulation segments drives the modulation memory read address. It performs segment changes aligned to the start of the target segment's cycle. It counts completed loops so that finite-repeat playback stops on the last sample.

---
 rtl/modulation_segment_swap.sv | 158 +++++++++++++++
 tb/tb_modulation_segment_swap.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/modulation_segment_swap.sv
// Selects which of the two modulation segments drives the read index. Segment
// changes are aligned to the start of the target segment's cycle, and completed
// loops are counted so that finite-repeat playback stops on the last sample.
module modulation_segment_swap #(
  parameter int NumSegment = 2,
  parameter int IdxWidth   = 15,
  parameter int RepWidth   = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                UPDATE_SETTINGS,
  input  logic                REQ_SEGMENT,
  input  logic [RepWidth-1:0] REP,
  input  logic [IdxWidth-1:0] CYCLE  [NumSegment],
  input  logic [IdxWidth-1:0] IDX_IN [NumSegment],
  output logic                SEGMENT,
  output logic [IdxWidth-1:0] IDX,
  output logic                STOP,
  output logic                SWAPPED
);

  typedef enum logic [1:0] {RUN, WAIT_START, FINISHED} state_t;

  localparam logic [RepWidth-1:0] One = RepWidth'(1);

  state_t                state_q, state_d;
  logic                  seg_d, stop_d, swapped_d;
  logic [IdxWidth-1:0]   idx_d;
  logic [RepWidth-1:0]   cnt_q, cnt_d;
  logic                  pend_seg_q, pend_seg_d;
  logic [RepWidth-1:0]   pend_rep_q, pend_rep_d;
  logic                  wait_stop_q, wait_stop_d;
  logic [IdxWidth-1:0]   prev_idx [NumSegment];
  logic [NumSegment-1:0] wrap;

  logic [IdxWidth-1:0]   cur_idx, cur_cyc;
  logic                  finite, cur_done, cur_dec, swap_now;

  // Per-segment wrap: the index fell below last cycle's value.
  always_comb begin
    wrap = '0;
    for (int unsigned i = 0; i < NumSegment; i++) begin
      wrap[i] = IDX_IN[i] < prev_idx[i];
    end
  end

  // Loop-accounting terms for the active segment and the pending swap trigger.
  always_comb begin
    cur_idx  = IDX_IN[SEGMENT];
    cur_cyc  = CYCLE[SEGMENT];
    finite   = cnt_q != '1;
    cur_done = finite && ((cur_cyc == '0) || (wrap[SEGMENT] && cnt_q == '0));
    cur_dec  = finite && (cur_cyc != '0) && wrap[SEGMENT] && (cnt_q != '0);
    swap_now = wrap[pend_seg_q] || (CYCLE[pend_seg_q] == '0);
  end

  // Next-state and output logic; a settings update overrides wraps and swaps.
  always_comb begin
    state_d     = state_q;
    seg_d       = SEGMENT;
    idx_d       = IDX;
    stop_d      = STOP;
    swapped_d   = 1'b0;
    cnt_d       = cnt_q;
    pend_seg_d  = pend_seg_q;
    pend_rep_d  = pend_rep_q;
    wait_stop_d = wait_stop_q;

    if (UPDATE_SETTINGS) begin
      if (REQ_SEGMENT == SEGMENT) begin
        state_d     = RUN;
        stop_d      = 1'b0;
        cnt_d       = REP;
        idx_d       = cur_idx;
        wait_stop_d = 1'b0;
      end else begin
        state_d     = WAIT_START;
        pend_seg_d  = REQ_SEGMENT;
        pend_rep_d  = REP;
        // An already exhausted old segment stays stopped while the swap is armed.
        wait_stop_d = (state_q == FINISHED) || (state_q == WAIT_START && wait_stop_q);
        idx_d       = wait_stop_d ? IDX : cur_idx;
      end
    end else begin
      case (state_q)
        RUN: begin
          idx_d = cur_idx;
          if (cur_done) begin
            state_d = FINISHED;
            stop_d  = 1'b1;
            idx_d   = cur_cyc;
          end else if (cur_dec) begin
            cnt_d = cnt_q - One;
          end
        end
        WAIT_START: begin
          if (swap_now) begin
            state_d     = RUN;
            seg_d       = pend_seg_q;
            idx_d       = '0;
            stop_d      = 1'b0;
            swapped_d   = 1'b1;
            cnt_d       = pend_rep_q;
            wait_stop_d = 1'b0;
          end else if (!wait_stop_q) begin
            idx_d = cur_idx;
            if (cur_done) begin
              wait_stop_d = 1'b1;
              stop_d      = 1'b1;
              idx_d       = cur_cyc;
            end else if (cur_dec) begin
              cnt_d = cnt_q - One;
            end
          end
        end
        FINISHED: begin
          stop_d = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State, output and bookkeeping registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= RUN;
      SEGMENT     <= 1'b0;
      IDX         <= '0;
      STOP        <= 1'b0;
      SWAPPED     <= 1'b0;
      cnt_q       <= '1;
      pend_seg_q  <= 1'b0;
      pend_rep_q  <= '1;
      wait_stop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      SEGMENT     <= seg_d;
      IDX         <= idx_d;
      STOP        <= stop_d;
      SWAPPED     <= swapped_d;
      cnt_q       <= cnt_d;
      pend_seg_q  <= pend_seg_d;
      pend_rep_q  <= pend_rep_d;
      wait_stop_q <= wait_stop_d;
    end
  end

  // Previous timer indices for wrap detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < NumSegment; i++) prev_idx[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NumSegment; i++) prev_idx[i] <= IDX_IN[i];
    end
  end

endmodule

// File: tb/tb_modulation_segment_swap.sv
// Bench for modulation_segment_swap: a timer emulation drives the indices, a
// loop-counting reference model predicts each cycle's outputs into a queue and
// an independent monitor compares them one cycle later.
module tb_modulation_segment_swap;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd = 1'b0;
  logic        req_seg = 1'b0;
  logic [15:0] rep = '0;
  logic [14:0] cyc    [2];
  logic [14:0] idx_in [2];
  logic        segment, stop, swapped;
  logic [14:0] idx;

  modulation_segment_swap #(.NumSegment(2), .IdxWidth(15), .RepWidth(16)) dut (
    .CLK(clk), .RST(rst), .UPDATE_SETTINGS(upd), .REQ_SEGMENT(req_seg), .REP(rep),
    .CYCLE(cyc), .IDX_IN(idx_in), .SEGMENT(segment), .IDX(idx), .STOP(stop),
    .SWAPPED(swapped)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit      seg;
    int      idx;
    bit      stop;
    bit      swapped;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: loops_left counts wraps still to play (-1 = endless).
  bit m_seg, m_stop, m_swapped, m_pending, m_finished, m_pseg;
  int m_idx, m_left, m_prep;
  int m_prev [2];
  int t_idx [2];

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int loops_for(input int r);
    return (r == 16'hFFFF) ? -1 : r + 1;
  endfunction

  function automatic int next_of(input int s);
    return (t_idx[s] == int'(cyc[s])) ? 0 : t_idx[s] + 1;
  endfunction

  task automatic model_reset();
    m_seg = 0; m_idx = 0; m_stop = 0; m_swapped = 0;
    m_left = -1; m_pending = 0; m_finished = 0; m_pseg = 0; m_prep = -1;
    m_prev[0] = 0; m_prev[1] = 0;
  endtask

  task automatic model_step(input bit u, input bit rs, input int rp);
    bit w [2];
    for (int s = 0; s < 2; s++) begin
      w[s] = t_idx[s] < m_prev[s];
      m_prev[s] = t_idx[s];
    end
    m_swapped = 0;
    if (u) begin
      if (rs == m_seg) begin
        m_pending = 0; m_finished = 0; m_stop = 0;
        m_left = loops_for(rp);
        m_idx = t_idx[m_seg];
      end else begin
        m_pending = 1; m_pseg = rs; m_prep = rp;
        if (!m_finished) m_idx = t_idx[m_seg];
      end
    end else if (m_pending && (w[m_pseg] || cyc[m_pseg] == 0)) begin
      m_seg = m_pseg; m_swapped = 1; m_stop = 0; m_finished = 0;
      m_left = loops_for(m_prep); m_idx = 0; m_pending = 0;
    end else if (!m_finished) begin
      m_idx = t_idx[m_seg];
      if (m_left >= 0) begin
        if (cyc[m_seg] == 0) begin
          m_finished = 1;
        end else if (w[m_seg]) begin
          m_left--;
          if (m_left == 0) m_finished = 1;
        end
        if (m_finished) begin
          m_stop = 1;
          m_idx = cyc[m_seg];
        end
      end
    end
    q.push_back('{seg: m_seg, idx: m_idx, stop: m_stop, swapped: m_swapped});
  endtask

  // One cycle of stimulus: advance the emulated timer, drive, predict.
  task automatic tick(input bit u = 0, input bit rs = 0, input logic [15:0] rp = '0);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      t_idx[s] = next_of(s);
      idx_in[s] = 15'(t_idx[s]);
    end
    upd = u; req_seg = rs; rep = rp;
    model_step(u, rs, int'(rp));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Idle until the next driven index of segment s would be v.
  task automatic run_until(input int s, input int v);
    int n = 0;
    while (next_of(s) != v && n < 64) begin
      tick();
      n++;
    end
    check("run_until_reached", int'(n < 64), 1);
  endtask

  // Asynchronous reset away from the clock edge; outputs must clear at once.
  task automatic do_reset(input int c0, input int c1);
    @(negedge clk);
    upd = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_segment", int'(segment), 0);
    check("rst_idx", int'(idx), 0);
    check("rst_stop", int'(stop), 0);
    check("rst_swapped", int'(swapped), 0);
    cyc[0] = 15'(c0); cyc[1] = 15'(c1);
    t_idx[0] = c0; t_idx[1] = c1;
    idx_in[0] = cyc[0]; idx_in[1] = cyc[1];
    model_reset();
    @(posedge clk);
    @(posedge clk);
  endtask

  // Monitor: every post-edge sample is checked against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("segment", int'(segment), int'(e.seg));
        check("idx", int'(idx), e.idx);
        check("stop", int'(stop), int'(e.stop));
        check("swapped", int'(swapped), int'(e.swapped));
      end
    end
  end

  initial begin
    cyc[0] = 15'd9; cyc[1] = 15'd7;
    idx_in[0] = '0; idx_in[1] = '0;
    model_reset();
    #3;
    check("init_segment", int'(segment), 0);
    check("init_stop", int'(stop), 0);
    check("init_swapped", int'(swapped), 0);

    // Endless playback of segment 0 over several wraps.
    do_reset(9, 7);
    ticks(60);

    // Finite repeat: REP=2 on a 4-sample segment.
    do_reset(3, 7);
    ticks(3);
    tick(1, 0, 16'd2);
    ticks(25);

    // Aligned swap to segment 1 requested mid-cycle.
    tick(1, 0, 16'hFFFF);
    run_until(1, 5);
    tick(1, 1, 16'hFFFF);
    ticks(12);

    // Request replacement: second request's repeat count is used.
    do_reset(3, 7);
    ticks(2);
    run_until(1, 3);
    tick(1, 1, 16'hFFFF);
    tick();
    tick(1, 1, 16'd1);
    ticks(30);

    // Update coinciding with a segment-0 wrap.
    do_reset(3, 7);
    ticks(2);
    run_until(0, 0);
    tick(1, 0, 16'd0);
    ticks(12);

    // Reset while a swap is pending.
    ticks(2);
    run_until(1, 2);
    tick(1, 1, 16'hFFFF);
    ticks(2);
    do_reset(3, 7);
    ticks(20);

    // Single-sample segments.
    do_reset(0, 4);
    tick(1, 0, 16'd1);
    ticks(5);
    tick(1, 1, 16'd3);
    ticks(25);
    do_reset(5, 0);
    ticks(3);
    tick(1, 1, 16'd2);
    ticks(8);

    // Randomised traffic.
    for (int b = 0; b < 4; b++) begin
      do_reset(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      for (int k = 0; k < 250; k++) begin
        if ($urandom_range(0, 11) == 0) begin
          logic [15:0] r;
          case ($urandom_range(0, 4))
            0: r = 16'd0;
            1: r = 16'd1;
            2: r = 16'd2;
            3: r = 16'd3;
            default: r = 16'hFFFF;
          endcase
          tick(1, 1'($urandom_range(0, 1)), r);
        end else begin
          tick();
        end
      end
    end

    @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
